ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Instruction fetch front-end that sits directly upstream of the instruction cache. It generates sequential fetch addresses and drives the icache CPU-side read port (`ufp_*`), buffering returned instructions with their PCs in a small FIFO for decode. It also handles pipeline redirects, including squashing an icache response that is already in flight.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h1ECEB000: first fetch address after reset.
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `imem_addr` out 32: fetch address to icache `ufp_addr`; bits [1:0] always 0.
- `imem_rmask` out 4: to icache `ufp_rmask`; 4'hF = request, 4'h0 = none.
- `imem_rdata` in 32: icache `ufp_rdata`.
- `imem_resp` in 1: icache `ufp_resp`.
- `redirect` in 1: flush and restart fetch.
- `redirect_pc` in 32: new PC; bits [1:0] ignored (forced 0).
- `deq_valid` out 1: head entry valid.
- `deq_ready` in 1: decode accepts head.
- `deq_inst` out 32: head instruction.
- `deq_pc` out 32: head PC.

## Operation
- State: `fetch_pc`, FIFO (`DEPTH` × {pc, inst}), `count` (width clog2(DEPTH)+1), read/write pointers (clog2(DEPTH) bits, wrap modulo DEPTH), FSM {IDLE, WAIT, DISCARD}.
- At most one icache request outstanding.
- The request is level: `imem_rmask`=4'hF and `imem_addr`=`fetch_pc` are held stable from issue until the `imem_resp` cycle.
- Issue rule: issue when `count_next` < DEPTH. `count_next` is count after this cycle's push/pop. This reserves a slot for the response.
- IDLE:
  - Issue if space → WAIT.
  - Otherwise stay IDLE, rmask=0.
- WAIT, `imem_resp`=1, no redirect:
  - Push {`fetch_pc`, `imem_rdata`}; `fetch_pc` += 4 (wraps at 2^32).
  - If space remains, present the next request in the same cycle (back-to-back) and stay in WAIT; else → IDLE.
- Redirect (highest priority, any state):
  - FIFO flushed (count, pointers → 0).
  - `fetch_pc` ← {`redirect_pc`[31:2], 2'b0}.
  - `deq_valid` forced 0 in the redirect cycle; pops that cycle are ignored.
- Redirect in WAIT without `imem_resp`:
  - → DISCARD. The old address/rmask stay held until `imem_resp`, then the data is dropped → IDLE.
- Redirect in the same cycle as `imem_resp`:
  - Response dropped → IDLE. New request issues the next cycle.
- Redirect in DISCARD:
  - Update `fetch_pc`, remain in DISCARD.
- Simultaneous push and pop with FIFO full or empty is legal; count unchanged.

## Timing
- Reset values:
  - `imem_rmask`=0, `imem_addr`=RESET_PC, `deq_valid`=0, `deq_inst`=0, `deq_pc`=0.
  - count=0, FSM=IDLE, `fetch_pc`=RESET_PC.
- First request is asserted in the first cycle after `rst` deasserts.
- Response-to-dequeue latency: `imem_resp` in cycle N → `deq_valid` in cycle N+1 (no bypass).
- Throughput: with icache hits every cycle and `deq_ready`=1, one instruction per cycle.
- After redirect in cycle R with nothing in flight, a request with `imem_addr`=`redirect_pc` is asserted in cycle R+1.
- `rst` mid-request: all state returns to reset values. The next icache response is not expected; the icache is reset on the same `rst`.

## Configuration
- `IFETCH_BYPASS_EN`:
  - Defined: when FIFO is empty and a non-discarded `imem_resp` arrives, `deq_valid`/`deq_inst`/`deq_pc` reflect it combinationally in the same cycle.
    - If `deq_ready`=1, the entry is not written into the FIFO.
    - If `deq_ready`=0, it is pushed normally.
  - Undefined: no bypass; latency is exactly 1 cycle as in Timing.

## Test plan
- Reset, icache resp every cycle with rdata = addr ^ 32'hA5A5A5A5, `deq_ready`=1 → deq_pc sequence 1ECEB000, 1ECEB004, …; first `deq_valid` one cycle after first resp; 1 inst/cycle.
- `deq_ready`=0 for 20 cycles, resp every cycle → exactly 8 pushes; rmask drops to 0 after the 8th; no overflow. Release `deq_ready` → fetch resumes.
- Redirect to 32'h0000_1002 while WAIT with resp delayed 5 cycles → addr held until resp, data dropped, next request addr=32'h0000_1000, first deq_pc=32'h0000_1000.
- Redirect coincident with resp and FIFO holding 3 entries → `deq_valid`=0 next cycle; resp data never dequeued; request 32'h…(redirect_pc) next cycle.
- `fetch_pc`=32'hFFFF_FFFC, resp → next request addr=32'h0000_0000.
- With `IFETCH_BYPASS_EN`, empty FIFO, resp and `deq_ready`=1 → `deq_valid` the same cycle; count stays 0.

Source files
------------

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - Sequential instruction fetch driving the icache read port, with a {pc, inst} FIFO toward decode
// Optional feature macro: IFETCH_BYPASS_EN (forward a live response to decode in the same cycle when the FIFO is empty)
module ifetch_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h1ECEB000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        deq_valid,
    input  logic        deq_ready,
    output logic [31:0] deq_inst,
    output logic [31:0] deq_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        req_addr_q, req_addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

    logic [31:0]        pc_mem   [DEPTH];
    logic [31:0]        inst_mem [DEPTH];

    logic               fifo_valid;
    logic               resp_live;
    logic               bypass_hit;
    logic               push;
    logic               pop;
    logic               issue;
    logic [31:0]        issue_addr;
    logic [31:0]        pc_plus4;
    logic [CNT_W-1:0]   count_next;

    // FIFO bookkeeping: who pushes, who pops, and the occupancy after this cycle
    always_comb begin
        fifo_valid = (count_q != '0);
        pc_plus4   = fetch_pc_q + 32'd4;
        resp_live  = (state_q == ST_WAIT) && imem_resp && !redirect && !rst;
        bypass_hit = 1'b0;
`ifdef IFETCH_BYPASS_EN
        bypass_hit = resp_live && !fifo_valid;
`endif
        pop        = fifo_valid && deq_ready && !redirect && !rst;
        // A bypassed response that decode takes immediately never occupies a slot
        push       = resp_live && !(bypass_hit && deq_ready);
        count_next = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end

    // Fetch FSM: issue decisions, fetch_pc advance, redirect handling and pointer updates
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        count_d    = count_next;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        issue      = 1'b0;
        issue_addr = fetch_pc_q;

        case (state_q)
            ST_IDLE: begin
                // Issue only if the eventual response is guaranteed a slot
                if (!redirect && (count_next < DEPTH_C)) begin
                    issue      = 1'b1;
                    issue_addr = fetch_pc_q;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    // A response already in flight must still be absorbed before fetching anew
                    state_d = imem_resp ? ST_IDLE : ST_DISCARD;
                end else if (imem_resp) begin
                    fetch_pc_d = pc_plus4;
                    if (count_next < DEPTH_C) begin
                        issue      = 1'b1;
                        issue_addr = pc_plus4;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DISCARD: begin
                if (imem_resp) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue) begin
            req_addr_d = issue_addr;
        end

        if (redirect) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    // Icache request: held for the outstanding address, dropped in the response cycle unless a new one issues
    always_comb begin
        imem_rmask = 4'h0;
        imem_addr  = issue ? issue_addr : req_addr_q;
        if (rst) begin
            imem_addr = RESET_PC;
        end else if (issue || ((state_q != ST_IDLE) && !imem_resp)) begin
            imem_rmask = 4'hF;
        end
    end

    // Decode-side head: FIFO head, or the live response when bypassing into an empty FIFO
    always_comb begin
        deq_valid = 1'b0;
        deq_inst  = 32'h0;
        deq_pc    = 32'h0;
        if (!rst && !redirect) begin
            if (fifo_valid) begin
                deq_valid = 1'b1;
                deq_inst  = inst_mem[rd_ptr_q];
                deq_pc    = pc_mem[rd_ptr_q];
            end else if (bypass_hit) begin
                deq_valid = 1'b1;
                deq_inst  = imem_rdata;
                deq_pc    = fetch_pc_q;
            end
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage; reads are qualified by count so the array needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            inst_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - Randomized scoreboard bench for ifetch_queue with a behavioural icache and fetch model
module tb_ifetch_queue;

    localparam int unsigned DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h1ECEB000;
    localparam logic [31:0] XORK     = 32'hA5A5A5A5;
`ifdef IFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_resp = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [31:0] deq_inst;
    logic [31:0] deq_pc;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_inst(deq_inst), .deq_pc(deq_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_deq = 0;
    int          n_latch = 0;

    // icache model state
    bit          c_busy = 0;
    bit          c_dead = 0;
    int          c_wait = 0;
    logic [31:0] c_addr = 32'h0;
    int          force_delay = 0;
    int          dly_max = 1;
    int          rdy_pct = 100;

    // reference fetch model
    logic [31:0] exp_pc = RESET_PC;
    bit          exp_dv = 0;
    bit          mon_en = 0;
    bit          saw_zero = 0;
    bit          last_red = 0;
    logic [3:0]  last_rmask = 4'h0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] last_latch_addr = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, play the icache, advance the reference model
    task automatic step(input logic do_rst, input logic red, input logic [31:0] rpc, input logic red_on_resp);
        int   occ;
        logic resp_now;
        logic live;
        logic red_eff;
        @(negedge clk);
        occ       = exp_q.size();
        rst       = do_rst;
        deq_ready = ($urandom_range(99) < rdy_pct);
        resp_now  = 1'b0;
        if (!do_rst && c_busy) begin
            if (c_wait <= 1) resp_now = 1'b1;
            else c_wait--;
        end
        red_eff     = !do_rst && (red || (red_on_resp && resp_now));
        last_red    = red_eff;
        redirect    = red_eff;
        redirect_pc = rpc;
        imem_resp   = resp_now;
        imem_rdata  = resp_now ? (c_addr ^ XORK) : $urandom;
        #1;
        if (do_rst) begin
            c_busy = 0; c_dead = 0; exp_q.delete(); exp_pc = RESET_PC;
            mon_en = 0; exp_dv = 0;
            last_rmask = imem_rmask; last_addr = imem_addr;
            return;
        end
        mon_en = 1;
        if (c_busy && !resp_now) begin
            chk("hold_rmask", {60'h0, imem_rmask}, 64'hF);
            chk("hold_addr", {32'h0, imem_addr}, {32'h0, c_addr});
        end
        live   = resp_now && !c_dead && !red_eff;
        exp_dv = !red_eff && ((occ > 0) || (BYP && live));
        if (resp_now) begin
            c_busy = 0;
            if (live) begin
                exp_q.push_back('{pc: exp_pc, inst: exp_pc ^ XORK});
                exp_pc = exp_pc + 32'd4;
                chk("no_overflow", {63'h0, (exp_q.size() <= DEPTH)}, 64'h1);
            end
            c_dead = 0;
        end
        if (red_eff) begin
            exp_q.delete();
            exp_pc = {rpc[31:2], 2'b00};
            if (c_busy) c_dead = 1;
        end
        last_rmask = imem_rmask;
        last_addr  = imem_addr;
        if (!c_busy && imem_rmask == 4'hF) begin
            c_busy = 1;
            c_addr = imem_addr;
            c_wait = (force_delay != 0) ? force_delay : $urandom_range(dly_max, 1);
            n_latch++;
            last_latch_addr = imem_addr;
            if (imem_addr == 32'h0) saw_zero = 1;
            chk("req_addr", {32'h0, imem_addr}, {32'h0, exp_pc});
        end
    endtask

    // Monitor: compares the decode-side output against the scoreboard every cycle
    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            chk("deq_valid", {63'h0, deq_valid}, {63'h0, exp_dv});
            if (deq_valid && deq_ready) begin
                if (exp_q.size() == 0) begin
                    chk("deq_unexpected", {32'h0, deq_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    chk("deq_pc", {32'h0, deq_pc}, {32'h0, e.pc});
                    chk("deq_inst", {32'h0, deq_inst}, {32'h0, e.inst});
                    n_deq++;
                end
            end
        end
    end

    initial begin
        int k;
        // Reset values
        rdy_pct = 100;
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("rst_rmask", {60'h0, imem_rmask}, 64'h0);
        chk("rst_addr", {32'h0, imem_addr}, {32'h0, RESET_PC});
        chk("rst_deq_valid", {63'h0, deq_valid}, 64'h0);
        chk("rst_deq_inst", {32'h0, deq_inst}, 64'h0);
        chk("rst_deq_pc", {32'h0, deq_pc}, 64'h0);

        // Streaming at one response per cycle
        n_deq = 0;
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("first_req_rmask", {60'h0, last_rmask}, 64'hF);
        for (int i = 0; i < 29; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        chk("throughput", n_deq, BYP ? 64'd29 : 64'd28);

        // Decode stalled: FIFO fills to DEPTH and requests stop
        rdy_pct = 0;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        chk("full_count", exp_q.size(), DEPTH);
        chk("full_rmask", {60'h0, last_rmask}, 64'h0);
        rdy_pct = 100;
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("resume_rmask", {60'h0, last_rmask}, 64'hF);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Redirect while a slow response is outstanding
        force_delay = 6;
        k = n_latch;
        for (int i = 0; i < 20 && n_latch == k; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("slow_req_seen", {63'h0, (n_latch != k)}, 64'h1);
        force_delay = 0;
        step(1'b0, 1'b1, 32'h0000_1002, 1'b0);
        k = n_latch;
        for (int i = 0; i < 20 && n_latch == k; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("post_discard_addr", {32'h0, last_latch_addr}, 64'h0000_1000);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Redirect coincident with a response while three entries are queued
        rdy_pct = 0;
        for (int i = 0; i < 30 && exp_q.size() != 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("three_queued", exp_q.size(), 64'd3);
        step(1'b0, 1'b0, 32'h0000_2000, 1'b1);
        chk("coincident_redirect", {63'h0, last_red}, 64'h1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("redirect_req_rmask", {60'h0, last_rmask}, 64'hF);
        chk("redirect_req_addr", {32'h0, last_addr}, 64'h0000_2000);
        rdy_pct = 100;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Address wrap at the top of the space
        saw_zero = 0;
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("wrap_to_zero", {63'h0, saw_zero}, 64'h1);

        // Randomized traffic
        dly_max = 4;
        rdy_pct = 70;
        for (int i = 0; i < 2000; i++) begin
            logic r;
            logic ror;
            r   = ($urandom_range(99) < 3);
            ror = ($urandom_range(99) < 2);
            step(1'b0, r, $urandom, ror);
        end
        rdy_pct = 100;
        dly_max = 1;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
